// File: rtl/vx_mem_rsp_merge.sv
// vx_mem_rsp_merge
// Collects partial coalesced memory responses for one outstanding multi-lane
// request and emits one merged response once every requested lane is in.
// One table entry per in-flight request, indexed by the low tag bits.
// The output is a one-deep register that supports load and drain in the
// same cycle, so back-to-back merged responses are possible.
//
// Optional build macro: VX_MEM_RSP_MERGE_CHECK_EN
//   defined   : beats to invalid entries, beats whose lanes were already
//               received, and beats with lanes outside the expected mask
//               are accepted and dropped, and they set the sticky err_out.
//   undefined : err_out is held at 0 and beats are merged without checks.

module vx_mem_rsp_merge #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int QUEUE_SIZE = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           req_valid_in,
    input  logic [NUM_REQS-1:0]            req_mask_in,
    input  logic [TAG_WIDTH-1:0]           req_tag_in,
    output logic                           req_ready_in,

    input  logic                           rsp_valid_in,
    input  logic [NUM_REQS-1:0]            rsp_mask_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_in,
    input  logic [TAG_WIDTH-1:0]           rsp_tag_in,
    output logic                           rsp_ready_in,

    output logic                           rsp_valid_out,
    output logic [NUM_REQS-1:0]            rsp_mask_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_out,
    output logic [TAG_WIDTH-1:0]           rsp_tag_out,
    input  logic                           rsp_ready_out,

    output logic                           err_out
);

    localparam int IDX_BITS = $clog2(QUEUE_SIZE);

    typedef logic [NUM_REQS-1:0][DATA_WIDTH-1:0] lane_data_t;

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    logic [QUEUE_SIZE-1:0] valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q  [QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  tag_d  [QUEUE_SIZE];
    logic [NUM_REQS-1:0]   exp_q  [QUEUE_SIZE];
    logic [NUM_REQS-1:0]   exp_d  [QUEUE_SIZE];
    logic [NUM_REQS-1:0]   rcv_q  [QUEUE_SIZE];
    logic [NUM_REQS-1:0]   rcv_d  [QUEUE_SIZE];
    lane_data_t            data_q [QUEUE_SIZE];
    lane_data_t            data_d [QUEUE_SIZE];

    // Output register and sticky error
    logic                  out_valid_q, out_valid_d;
    logic [NUM_REQS-1:0]   out_mask_q,  out_mask_d;
    lane_data_t            out_data_q,  out_data_d;
    logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
    logic                  err_q,       err_d;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming request and response beat
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0]   req_idx_s;
    logic [IDX_BITS-1:0]   rsp_idx_s;
    logic                  rsp_ent_valid_s;
    logic [NUM_REQS-1:0]   rsp_exp_s;
    logic [NUM_REQS-1:0]   rsp_rcv_s;
    logic [NUM_REQS-1:0]   merged_rcv_s;
    lane_data_t            rsp_lane_s;
    lane_data_t            merged_data_s;
    logic                  beat_bad_s;
    logic                  completes_s;
    logic                  req_ready_s;
    logic                  rsp_ready_s;
    logic                  req_fire_s;
    logic                  rsp_fire_s;
    logic                  out_load_s;
    logic                  unused_rsp_tag_s;

    assign req_idx_s       = req_tag_in[IDX_BITS-1:0];
    assign rsp_idx_s       = rsp_tag_in[IDX_BITS-1:0];
    assign rsp_ent_valid_s = valid_q[rsp_idx_s];
    assign rsp_exp_s       = exp_q[rsp_idx_s];
    assign rsp_rcv_s       = rcv_q[rsp_idx_s];
    assign merged_rcv_s    = rsp_rcv_s | rsp_mask_in;
    assign rsp_lane_s      = rsp_data_in;

    // Only the index bits of the response tag select an entry; the stored
    // tag is what goes out with the merged response.
    assign unused_rsp_tag_s = &{1'b0, rsp_tag_in};

`ifdef VX_MEM_RSP_MERGE_CHECK_EN
    // A beat is illegal if its entry is not allocated, if it repeats a lane
    // already received, or if it carries a lane the request never asked for.
    assign beat_bad_s = !rsp_ent_valid_s
                     || (|(rsp_mask_in & rsp_rcv_s))
                     || (|(rsp_mask_in & ~rsp_exp_s));
`else
    assign beat_bad_s = 1'b0;
`endif

    // A beat only completes a live entry; a completing beat needs room in
    // the output register, everything else is always accepted.
    assign completes_s = rsp_valid_in && rsp_ent_valid_s && !beat_bad_s
                      && (merged_rcv_s == rsp_exp_s);
    assign rsp_ready_s = !reset && (!completes_s || !out_valid_q || rsp_ready_out);
    assign req_ready_s = !reset && !valid_q[req_idx_s];

    assign req_fire_s  = req_valid_in && req_ready_s;
    assign rsp_fire_s  = rsp_valid_in && rsp_ready_s;
    assign out_load_s  = rsp_fire_s && completes_s;

    // Merge this beat's lanes over the stored data for the addressed entry.
    always_comb begin
        merged_data_s = data_q[rsp_idx_s];
        for (int l = 0; l < NUM_REQS; l++) begin
            if (rsp_mask_in[l]) begin
                merged_data_s[l] = rsp_lane_s[l];
            end else begin
                merged_data_s[l] = data_q[rsp_idx_s][l];
            end
        end
    end

    // Next state of the table: merge or retire on a beat, then allocate.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        exp_d   = exp_q;
        rcv_d   = rcv_q;
        data_d  = data_q;

        if (rsp_fire_s && !beat_bad_s) begin
            if (completes_s) begin
                // Entry is retired at the same edge its data moves out.
                valid_d[rsp_idx_s] = 1'b0;
                rcv_d[rsp_idx_s]   = {NUM_REQS{1'b0}};
            end else begin
                rcv_d[rsp_idx_s]   = merged_rcv_s;
                data_d[rsp_idx_s]  = merged_data_s;
            end
        end else begin
            valid_d = valid_q;
        end

        // Allocation only targets an entry whose registered valid is low,
        // so it can never collide with a completion on the same entry.
        if (req_fire_s) begin
            valid_d[req_idx_s] = 1'b1;
            tag_d[req_idx_s]   = req_tag_in;
            exp_d[req_idx_s]   = req_mask_in;
            rcv_d[req_idx_s]   = {NUM_REQS{1'b0}};
        end else begin
            tag_d = tag_d;
        end
    end

    // Next state of the output register and the sticky error flag.
    always_comb begin
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;

        if (out_load_s) begin
            out_valid_d = 1'b1;
            out_mask_d  = rsp_exp_s;
            out_data_d  = merged_data_s;
            out_tag_d   = tag_q[rsp_idx_s];
        end else if (out_valid_q && rsp_ready_out) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        err_d = err_q | (rsp_fire_s & beat_bad_s);
    end

    // Register all state; synchronous reset drops every entry and output.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= {QUEUE_SIZE{1'b0}};
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                tag_q[i]  <= {TAG_WIDTH{1'b0}};
                exp_q[i]  <= {NUM_REQS{1'b0}};
                rcv_q[i]  <= {NUM_REQS{1'b0}};
                data_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_mask_q  <= {NUM_REQS{1'b0}};
            out_data_q  <= '0;
            out_tag_q   <= {TAG_WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            exp_q       <= exp_d;
            rcv_q       <= rcv_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_in  = req_ready_s;
    assign rsp_ready_in  = rsp_ready_s;
    assign rsp_valid_out = out_valid_q;
    assign rsp_mask_out  = out_mask_q;
    assign rsp_data_out  = out_data_q;
    assign rsp_tag_out   = out_tag_q;
    assign err_out       = err_q;

endmodule

// File: doc/vx_mem_rsp_merge.md
# vx_mem_rsp_merge

Downstream companion to the per-lane memory response selector. It collects partial coalesced responses (tag plus lane mask plus per-lane data) that belong to one outstanding multi-lane request and emits a single merged response once every lane named in the original request mask has arrived. It sits between the response selector and the LSU writeback path, holding one table entry per in-flight request, indexed by the low tag bits.

## Interface
- NUM_REQS, 4: lanes per request.
- DATA_WIDTH, 32: per-lane data bits.
- TAG_WIDTH, 8: full request tag width.
- QUEUE_SIZE, 4: table entries; power of two, ≥2, ≤2^TAG_WIDTH. IDX_BITS = log2(QUEUE_SIZE).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  1  allocate an entry for a new request.
- req_mask_in  in  NUM_REQS  lanes that will respond; nonzero.
- req_tag_in  in  TAG_WIDTH  request tag; entry = req_tag_in[IDX_BITS-1:0].
- req_ready_in  out  1  the indexed entry is free.
- rsp_valid_in  in  1  partial response valid.
- rsp_mask_in  in  NUM_REQS  lanes carried by this beat.
- rsp_data_in  in  NUM_REQS×DATA_WIDTH  per-lane data; only masked lanes are meaningful.
- rsp_tag_in  in  TAG_WIDTH  response tag.
- rsp_ready_in  out  1  beat accepted.
- rsp_valid_out  out  1  merged response valid.
- rsp_mask_out  out  NUM_REQS  original request mask.
- rsp_data_out  out  NUM_REQS×DATA_WIDTH  merged data.
- rsp_tag_out  out  TAG_WIDTH  tag stored at allocation.
- rsp_ready_out  in  1  consumer ready.
- err_out  out  1  sticky protocol error (see Configuration).

## Operation
- Each entry holds: valid, tag, expected mask, received mask, and NUM_REQS data words.
- Allocation happens when req_valid_in && req_ready_in. It sets valid, stores the tag, sets expected = req_mask_in and received = 0. req_ready_in = !entry.valid, read from registered state only.
- Merge happens when rsp_valid_in && rsp_ready_in. For entry i = rsp_tag_in[IDX_BITS-1:0]: received |= rsp_mask_in, and data lanes with mask=1 are overwritten. Lanes with mask=0 are untouched.
- Completion: (received | rsp_mask_in) == expected on the accepting beat. On completion the merged entry (including this beat's data) is loaded into a one-deep output register and the entry is cleared at the same edge.
- rsp_ready_in = !completes || !rsp_valid_out || rsp_ready_out. Non-completing beats are always accepted. rsp_ready_in may depend combinationally on rsp_mask_in, rsp_tag_in and rsp_ready_out.
- Output register: loaded on completion, cleared on rsp_valid_out && rsp_ready_out with no new load. Load and drain may happen in the same cycle, which gives back-to-back output.
- An allocation and a merge to different entries in the same cycle are independent. An allocation to an entry that completes in the same cycle is refused, because req_ready_in sees the registered valid=1. The entry is allocatable the next cycle.

## Timing
- Latency: the completing beat is accepted at edge N and rsp_valid_out is high in cycle N+1. A single beat carrying the full mask therefore has 1-cycle latency.
- Throughput: one merged response per cycle with rsp_ready_out held high.
- rsp_valid_out and the output fields are held stable while rsp_valid_out && !rsp_ready_out.
- Reset values: all entries invalid, rsp_valid_out=0, rsp_mask_out/data/tag = 0, err_out=0. While reset is high, req_ready_in=0 and rsp_ready_in=0.
- Reset mid-operation drops all partial entries and any pending output with no response emitted. The first cycle after reset deasserts has req_ready_in=1 for every index.

## Configuration
- VX_MEM_RSP_MERGE_CHECK_EN defined:
  - err_out is set, sticky until reset, when an accepted beat targets an invalid entry.
  - err_out is also set when a beat's mask overlaps the received mask or has lanes outside the expected mask.
  - Such beats are still accepted and dropped; the entry is not modified.
- Not defined: err_out is tied to 0, no checks are made, and beats are merged blindly per the rules above.

## Test plan
- Alloc tag 0x05 mask 4'b1111. Send beats mask 4'b0011 (data A,B), then 4'b1100 (C,D). Expect one output one cycle after the second beat: mask 4'b1111, tag 0x05, data {D,C,B,A}.
- Alloc tag 0x02 mask 4'b0101. Send one beat with mask 4'b0101. Expect rsp_valid_out in the next cycle; the entry becomes re-allocatable in that same cycle.
- Hold rsp_ready_out=0 with a pending output, then complete a second entry. Expect rsp_ready_in=0 for the completing beat, rsp_ready_in=1 for a partial beat, and outputs stable. Release ready: two outputs on consecutive cycles.
- Alloc tags 0x01 and 0x05 with QUEUE_SIZE=4 (same index 1). Expect the second allocation stalled (req_ready_in=0) until the first completes and is loaded.
- Assert reset after one partial beat to tag 0x03. Expect no output, and all req_ready_in=1 after reset.
- With CHECK_EN defined, send a beat to an unallocated tag 0x07. Expect err_out=1 next cycle, staying high, and no output. Without the macro, err_out stays 0.
